scope_capture: RTL and testbench

- Upstream feeder of the 640x480 VGA timing/colour stage.
- Takes a decimated, triggered ADC sample stream into a double-buffered 640-sample store.
- Renders the stored trace, one column per sample, into the 8-bit `pixels` strip the VGA stage consumes.
- Bank swaps happen only at the start of the bottom blanking region, so no frame tears.

---
 rtl/scope_pkg.sv | 31 +++
 rtl/scope_capture_if.sv | 30 +++
 rtl/sample_ram_dp.sv | 22 ++
 rtl/scope_capture.sv | 179 +++++++++++++++++
 tb/tb_scope_capture.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/scope_pkg.sv
// Shared constants, FSM encoding and row mapping for the oscilloscope capture/render path.
package scope_pkg;

    localparam int unsigned SAMPLE_W  = 8;
    localparam int unsigned DEPTH     = 640;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DECIM_W   = 4;
    localparam int unsigned HC_W      = 11;
    localparam int unsigned VC_W      = 10;
    localparam int unsigned ROW_W     = 10;
    localparam int unsigned PIX_W     = 8;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_TOTAL   = 525;
    localparam int unsigned ROW_BASE  = 367;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Screen row of a sample value; larger samples sit higher on screen.
    function automatic logic [ROW_W-1:0] sample_row(input logic [SAMPLE_W-1:0] s);
        return ROW_W'(ROW_BASE) - ROW_W'(s);
    endfunction

endpackage

// File: rtl/scope_capture_if.sv
// ADC stream, trigger controls, VGA counters and trace/status outputs of scope_capture.
interface scope_capture_if;
    import scope_pkg::*;

    logic [SAMPLE_W-1:0] adc_data;
    logic                adc_valid;
    logic [SAMPLE_W-1:0] trig_level;
    logic                trig_rising;
    logic [DECIM_W-1:0]  decim;
    logic [HC_W-1:0]     hcounter;
    logic [VC_W-1:0]     vcounter;
    logic                lower_blank;
    logic [PIX_W-1:0]    pixels;
    logic                armed;
    logic                capturing;
    logic                frame_ready;

    modport master (
        output adc_data, adc_valid, trig_level, trig_rising, decim,
               hcounter, vcounter, lower_blank,
        input  pixels, armed, capturing, frame_ready
    );

    modport slave (
        input  adc_data, adc_valid, trig_level, trig_rising, decim,
               hcounter, vcounter, lower_blank,
        output pixels, armed, capturing, frame_ready
    );

endinterface

// File: rtl/sample_ram_dp.sv
// DEPTH x SAMPLE_W sample store: one write port, one registered read port.
module sample_ram_dp
    import scope_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/scope_capture.sv
// Triggered, decimated capture into a double-buffered trace store, rendered as an 8-column pixel strip.
module scope_capture
    import scope_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    scope_capture_if.slave  bus
);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d, waddr_c;
    logic                 disp_bank_q, disp_bank_d;
    logic                 disp_valid_q, disp_valid_d;
    logic                 armed_q, armed_d;
    logic                 capturing_q, capturing_d;
    logic                 frame_ready_q, frame_ready_d;
    logic                 we_c;
    logic [DECIM_W-1:0]   dcnt_q;
    logic [SAMPLE_W-1:0]  prev_s_q;
    logic                 lb_q;
    logic                 accept_c, trig_c, lb_rise_c;

    assign accept_c  = bus.adc_valid && (dcnt_q == bus.decim);
    assign lb_rise_c = bus.lower_blank && !lb_q;
    assign trig_c    = bus.trig_rising
                     ? ((prev_s_q <  bus.trig_level) && (bus.adc_data >= bus.trig_level))
                     : ((prev_s_q >= bus.trig_level) && (bus.adc_data <  bus.trig_level));

    // Decimation counter, last accepted sample and lower_blank edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q   <= '0;
            prev_s_q <= '0;
            lb_q     <= 1'b0;
        end else begin
            lb_q <= bus.lower_blank;
            if (bus.adc_valid) begin
                dcnt_q <= accept_c ? '0 : dcnt_q + DECIM_W'(1);
            end
            if (accept_c) begin
                prev_s_q <= bus.adc_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_addr_q     <= '0;
            disp_bank_q   <= 1'b0;
            disp_valid_q  <= 1'b0;
            armed_q       <= 1'b0;
            capturing_q   <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            disp_bank_q   <= disp_bank_d;
            disp_valid_q  <= disp_valid_d;
            armed_q       <= armed_d;
            capturing_q   <= capturing_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    // Swap banks only from DONE on a lower_blank rise; an unfinished capture keeps running.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        disp_bank_d   = disp_bank_q;
        disp_valid_d  = disp_valid_q;
        frame_ready_d = 1'b0;
        we_c          = 1'b0;
        waddr_c       = wr_addr_q;
        case (state_q)
            ST_IDLE: state_d = ST_ARMED;
            ST_ARMED: begin
                if (accept_c && trig_c) begin
                    we_c      = 1'b1;
                    waddr_c   = '0;
                    wr_addr_d = ADDR_W'(1);
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (accept_c) begin
                    we_c = 1'b1;
                    if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (lb_rise_c) begin
                    disp_bank_d   = !disp_bank_q;
                    disp_valid_d  = 1'b1;
                    frame_ready_d = 1'b1;
                    state_d       = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        armed_d     = (state_d == ST_ARMED);
        capturing_d = (state_d == ST_CAPTURE);
    end

    logic [HC_W-1:0]     nh_c, nh2_c;
    logic [VC_W-1:0]     nv_c;
    logic [ADDR_W-1:0]   raddr_c;
    logic [SAMPLE_W-1:0] rdata0, rdata1, rdata_c, prev_rd_q;
    logic                rd_bank_q;
    logic [ROW_W-1:0]    cur_row_c, prv_row_c, lo_c, hi_c;
    logic                hit_c;
    logic [PIX_W-1:0]    pix_d, pix_q;

    // The RAM is addressed two columns ahead so its data lands while pixels for the next column are built.
    always_comb begin
        nh_c    = (bus.hcounter == HC_W'(H_TOTAL - 1)) ? '0 : bus.hcounter + HC_W'(1);
        nh2_c   = (nh_c == HC_W'(H_TOTAL - 1)) ? '0 : nh_c + HC_W'(1);
        nv_c    = bus.vcounter;
        if (bus.hcounter == HC_W'(H_TOTAL - 1)) begin
            nv_c = (bus.vcounter == VC_W'(V_TOTAL - 1)) ? '0 : bus.vcounter + VC_W'(1);
        end
        raddr_c = (nh2_c < HC_W'(H_VISIBLE)) ? ADDR_W'(nh2_c) : '0;
    end

    sample_ram_dp u_bank0 (
        .clk   (clk),
        .we    (we_c && disp_bank_q),
        .waddr (waddr_c),
        .wdata (bus.adc_data),
        .raddr (raddr_c),
        .rdata (rdata0)
    );

    sample_ram_dp u_bank1 (
        .clk   (clk),
        .we    (we_c && !disp_bank_q),
        .waddr (waddr_c),
        .wdata (bus.adc_data),
        .raddr (raddr_c),
        .rdata (rdata1)
    );

    assign rdata_c = rd_bank_q ? rdata1 : rdata0;

    // Vertical span between this column's row and the previous column's row draws the joins.
    always_comb begin
        cur_row_c = sample_row(rdata_c);
        prv_row_c = (nh_c == '0) ? cur_row_c : sample_row(prev_rd_q);
        lo_c      = (cur_row_c < prv_row_c) ? cur_row_c : prv_row_c;
        hi_c      = (cur_row_c < prv_row_c) ? prv_row_c : cur_row_c;
        hit_c     = (ROW_W'(nv_c) >= lo_c) && (ROW_W'(nv_c) <= hi_c);
        pix_d     = '0;
        if (hit_c && disp_valid_q && (nh_c < HC_W'(H_VISIBLE)) && (nv_c < VC_W'(V_VISIBLE))) begin
            pix_d = PIX_W'(1) << nh_c[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q     <= '0;
            rd_bank_q <= 1'b0;
            prev_rd_q <= '0;
        end else begin
            pix_q     <= pix_d;
            rd_bank_q <= disp_bank_q;
            prev_rd_q <= rdata_c;
        end
    end

    assign bus.pixels      = pix_q;
    assign bus.armed       = armed_q;
    assign bus.capturing   = capturing_q;
    assign bus.frame_ready = frame_ready_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: capture scenarios, bank swaps and rendered pixel probes.
module tb_scope_capture;
    import scope_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scope_capture_if bus ();

    scope_capture dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cap_cycles;
    int kt;
    int sine  [64];
    int trace [DEPTH];
    int nxt   [DEPTH];
    bit disp_ok;
    logic [7:0] exp_q [$];
    string      tag_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int col, input int row);
        int cur, prv, lo, hi;
        if (!disp_ok || col >= int'(H_VISIBLE) || row >= int'(V_VISIBLE)) return 8'h00;
        cur = int'(ROW_BASE) - trace[col];
        prv = (col == 0) ? cur : int'(ROW_BASE) - trace[col-1];
        lo  = (cur < prv) ? cur : prv;
        hi  = (cur < prv) ? prv : cur;
        if (row >= lo && row <= hi) return 8'(1 << (col % 8));
        return 8'h00;
    endfunction

    task automatic feed(input logic [7:0] v);
        bus.adc_data  = v;
        bus.adc_valid = 1'b1;
        step();
        if (bus.capturing) cap_cycles++;
    endtask

    // Walks the counters up to (h, v) so the pipeline has read columns h-1 and h, then compares.
    task automatic probe(input string tag, input int h, input int v);
        exp_q.push_back(exp_pix(h, v));
        tag_q.push_back(tag);
        bus.adc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int col, row;
            col = h - 3 + i;
            row = v;
            if (col < 0) begin
                col = col + int'(H_TOTAL);
                row = (v + int'(V_TOTAL) - 1) % int'(V_TOTAL);
            end
            bus.hcounter = 11'(col);
            bus.vcounter = 10'(row);
            if (i < 3) step();
        end
        check(tag_q.pop_front(), 32'(bus.pixels), 32'(exp_q.pop_front()));
    endtask

    task automatic blank_edge(input string tag, input bit expect_swap);
        bus.adc_valid   = 1'b0;
        bus.hcounter    = '0;
        bus.vcounter    = 10'd480;
        bus.lower_blank = 1'b1;
        step();
        check({tag, "_fr_first"}, 32'(bus.frame_ready), 32'(expect_swap));
        if (expect_swap) begin
            disp_ok = 1'b1;
            trace   = nxt;
        end
        step();
        check({tag, "_fr_second"}, 32'(bus.frame_ready), 32'(0));
        if (expect_swap) check({tag, "_armed"}, 32'(bus.armed), 32'(1));
        bus.lower_blank = 1'b0;
        step();
    endtask

    initial begin
        reset           = 1'b1;
        bus.adc_data    = '0;
        bus.adc_valid   = 1'b0;
        bus.trig_level  = 8'd128;
        bus.trig_rising = 1'b1;
        bus.decim       = '0;
        bus.hcounter    = '0;
        bus.vcounter    = '0;
        bus.lower_blank = 1'b0;
        disp_ok         = 1'b0;
        for (int k = 0; k < 64; k++) begin
            sine[k] = 128 + $rtoi($floor(100.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5));
        end

        step(); step(); step();
        check("rst_pixels", 32'(bus.pixels), 32'(0));
        check("rst_armed", 32'(bus.armed), 32'(0));
        check("rst_capturing", 32'(bus.capturing), 32'(0));
        check("rst_frame_ready", 32'(bus.frame_ready), 32'(0));
        reset = 1'b0;
        step();
        check("armed_after_reset", 32'(bus.armed), 32'(1));

        // Ramp triggers at value 128 (k=128); k=428 writes address 300, then reset abandons it.
        for (int k = 0; k <= 428; k++) feed(8'(k));
        check("capturing_at_300", 32'(bus.capturing), 32'(1));
        reset         = 1'b1;
        bus.adc_valid = 1'b0;
        step();
        check("midrst_capturing", 32'(bus.capturing), 32'(0));
        check("midrst_pixels", 32'(bus.pixels), 32'(0));
        reset = 1'b0;
        step();
        check("midrst_rearm", 32'(bus.armed), 32'(1));
        blank_edge("abort_no_swap", 1'b0);
        probe("abort_blank_display", 0, 239);

        // Full ramp capture, decim 0; later crossings while DONE must be ignored.
        cap_cycles = 0;
        for (int k = 0; k <= 767; k++) feed(8'(k));
        check("ramp_capture_len", 32'(cap_cycles), 32'(639));
        check("ramp_done_capturing", 32'(bus.capturing), 32'(0));
        for (int k = 768; k < 1024; k++) feed(8'(k));
        check("ramp_done_ignores_trig", 32'(bus.armed), 32'(0));
        for (int i = 0; i < int'(DEPTH); i++) nxt[i] = (128 + i) % 256;
        probe("ramp_pre_swap_blank", 0, 239);
        blank_edge("ramp_swap", 1'b1);
        probe("ramp_s0", 0, 239);
        probe("ramp_join", 5, 234);
        probe("ramp_miss", 5, 236);
        probe("ramp_top", 127, 112);
        probe("ramp_wrap_join", 128, 200);

        // decim 3: accepted values are multiples of 4, capture completes at vcounter 200.
        bus.decim    = 4'd3;
        bus.vcounter = 10'd200;
        cap_cycles   = 0;
        for (int k = 0; k <= 2683; k++) feed(8'(k + 1));
        check("decim_capture_len", 32'(cap_cycles), 32'(2556));
        probe("old_trace_persists", 5, 234);
        for (int i = 0; i < int'(DEPTH); i++) nxt[i] = (128 + 4 * i) % 256;
        blank_edge("decim_swap", 1'b1);
        probe("decim_s0", 0, 239);
        probe("decim_s1_join", 1, 237);
        probe("decim_s2_gap", 2, 236);

        // Falling trigger at 100 on a sine.
        bus.decim       = 4'd0;
        bus.trig_rising = 1'b0;
        bus.trig_level  = 8'd100;
        kt = 1;
        while (!(sine[(kt - 1) % 64] >= 100 && sine[kt % 64] < 100)) kt++;
        cap_cycles = 0;
        for (int k = 0; k <= kt + 639; k++) feed(8'(sine[k % 64]));
        check("sine_capture_len", 32'(cap_cycles), 32'(639));
        for (int i = 0; i < int'(DEPTH); i++) nxt[i] = sine[(kt + i) % 64];
        blank_edge("sine_swap", 1'b1);
        probe("sine_s0", 0, int'(ROW_BASE) - nxt[0]);
        probe("sine_s0_below_level", 0, int'(ROW_BASE) - 100);
        probe("sine_c10", 10, int'(ROW_BASE) - nxt[10]);
        probe("sine_c40_off", 40, 130);

        // Constant 0x40 after a rising crossing draws a flat line at row 303.
        bus.trig_rising = 1'b1;
        bus.trig_level  = 8'h40;
        feed(8'h00);
        for (int k = 0; k < int'(DEPTH); k++) feed(8'h40);
        for (int i = 0; i < int'(DEPTH); i++) nxt[i] = 64;
        blank_edge("const_swap", 1'b1);
        probe("const_h13", 13, 303);
        probe("const_h13_row302", 13, 302);
        probe("const_h0", 0, 303);
        probe("const_h639", 639, 303);
        probe("const_h640", 640, 303);
        probe("const_row480", 13, 480);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
